// File: rtl/ipml_prefetch_rd_ctrl_v2_0.sv
// FWFT read controller: turns a fixed-latency FIFO pop port into a valid/ready head word. Head word is visible RD_LATENCY+1 clocks after a pop.
// A consumer stall holds rd_data and rd_vld stable, and pops stop once the skid buffer is committed. PREFETCH_FLUSH_EN adds a flush input.
module ipml_prefetch_rd_ctrl_v2_0 #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                           rd_clk,
    input  logic                           rd_rst,
    input  logic                           src_empty,
    output logic                           src_rd_en,
    input  logic [DATA_WIDTH-1:0]          src_data,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_vld,
    input  logic                           rd_en,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level
`ifdef PREFETCH_FLUSH_EN
    ,
    input  logic                           flush
`endif
);
    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam int SW = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    generate
        if (BUF_DEPTH < RD_LATENCY + 1) begin : g_depth_chk
            $error("ipml_prefetch_rd_ctrl_v2_0: BUF_DEPTH must be >= RD_LATENCY+1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [RD_LATENCY-1:0] infl;
    logic [CW-1:0]         infl_cnt;
    logic                  flush_i;
    logic                  pop;
    logic                  wr;
    logic                  room;

`ifdef PREFETCH_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            infl_cnt = infl_cnt + CW'(infl[i]);
    end

    // Count in-flight words as already occupying a slot so a returning word always has space.
    assign room      = (SW'(level) + SW'(infl_cnt)) < SW'(BUF_DEPTH);
    assign rd_vld    = (level != '0);
    assign pop       = rd_vld & rd_en & ~flush_i;
    assign wr        = infl[RD_LATENCY-1] & ~flush_i;
    assign src_rd_en = ~src_empty & ~rd_rst & ~flush_i & (room | pop);
    assign rd_data   = rd_vld ? mem[head] : '0;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            infl <= '0;
        end else if (flush_i) begin
            infl <= '0;
        end else begin
            infl[0] <= src_rd_en;
            for (int i = 1; i < RD_LATENCY; i++)
                infl[i] <= infl[i-1];
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else if (flush_i) begin
            head  <= tail;
            level <= '0;
        end else begin
            if (wr)
                tail <= nxt(tail);
            if (pop)
                head <= nxt(head);
            case ({wr, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (wr)
            mem[tail] <= src_data;
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst) wr |-> (level < LW'(BUF_DEPTH)));

endmodule

// File: tb/tb_ipml_prefetch_rd_ctrl_v2_0.sv
// Bench for ipml_prefetch_rd_ctrl_v2_0 at RD_LATENCY=2, BUF_DEPTH=3 against a queue-based reference model.
// The flush scenario runs only when PREFETCH_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_ipml_prefetch_rd_ctrl_v2_0;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int D  = 3;
    localparam int LW = $clog2(D + 1);

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          src_empty;
    logic          src_rd_en;
    logic          rd_vld;
    logic          rd_en;
    logic          flush;
    logic [DW-1:0] src_data;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] level;

    always #5 rd_clk = ~rd_clk;

    ipml_prefetch_rd_ctrl_v2_0 #(.DATA_WIDTH(DW), .RD_LATENCY(L), .BUF_DEPTH(D)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .src_empty(src_empty), .src_rd_en(src_rd_en),
        .src_data(src_data), .rd_data(rd_data), .rd_vld(rd_vld), .rd_en(rd_en), .level(level)
`ifdef PREFETCH_FLUSH_EN
        , .flush(flush)
`endif
    );

    // Standard-mode source FIFO: data appears L clocks after a pop; reset empties it.
    logic [DW-1:0] src_mem [1024];
    int unsigned   wc = 0;
    int unsigned   rp = 0;
    logic [DW-1:0] pipe [L];
    assign src_empty = (rp == wc);
    assign src_data  = pipe[L-1];

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rp <= wc;
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else begin
            if (src_rd_en) begin
                pipe[0] <= src_mem[rp[9:0]];
                rp      <= rp + 1;
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Reference model: words waiting in the source, words in flight with their arrival cycle, buffered words.
    typedef struct { logic [DW-1:0] w; int rdy; } fly_t;
    logic [DW-1:0] m_src[$];
    logic [DW-1:0] m_buf[$];
    fly_t          m_fly[$];
    int cyc_n = 0, consumed = 0, nchk = 0, npass = 0, nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input logic [DW-1:0] w);
        src_mem[wc[9:0]] = w;
        wc++;
        if (!rd_rst) m_src.push_back(w);
    endtask

    task automatic model_reset();
        m_src.delete();
        m_buf.delete();
        m_fly.delete();
    endtask

    task automatic sample();
        fly_t          f;
        int            lvl;
        logic          e_vld, e_pop, e_sre;
        logic [DW-1:0] e_dat;
        while (m_fly.size() > 0 && m_fly[0].rdy <= cyc_n) begin
            f = m_fly.pop_front();
            m_buf.push_back(f.w);
        end
        @(negedge rd_clk);
        lvl   = m_buf.size();
        e_vld = (lvl != 0);
        e_dat = e_vld ? m_buf[0] : '0;
        e_pop = e_vld && rd_en && !flush;
        e_sre = !rd_rst && !flush && (m_src.size() != 0) && ((lvl + m_fly.size() < D) || e_pop);
        chk("rd_vld", 64'(rd_vld), 64'(e_vld));
        chk("rd_data", 64'(rd_data), 64'(e_dat));
        chk("level", 64'(level), 64'(lvl));
        chk("src_rd_en", 64'(src_rd_en), 64'(e_sre));
        if (e_pop) begin
            void'(m_buf.pop_front());
            consumed++;
        end
        if (e_sre) begin
            f.w   = m_src.pop_front();
            f.rdy = cyc_n + L + 1;
            m_fly.push_back(f);
        end
        if (flush) begin
            m_buf.delete();
            m_fly.delete();
        end
    endtask

    task automatic adv();
        @(posedge rd_clk);
        #1;
        cyc_n++;
        if (rd_rst) model_reset();
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        rd_en  = 1'b0;
        flush  = 1'b0;
        model_reset();
        sample();
        adv();
        rd_rst = 1'b0;
    endtask

    initial begin
        int pushed;
        rd_rst = 1'b1;
        rd_en  = 1'b0;
        flush  = 1'b0;
        #1;
        chk("reset_rd_vld", 64'(rd_vld), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_src_rd_en", 64'(src_rd_en), 64'd0);
        do_reset();

        // Fill with consumer stalled.
        for (int k = 0; k < 10; k++) push_src(32'hA000_0000 + 32'(k));
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("t1_src_rd_en", 64'(src_rd_en), 64'(i < 3));
            chk("t1_rd_vld", 64'(rd_vld), 64'(i >= 3));
            chk("t1_level", 64'(level), (i < 3) ? 64'd0 : 64'((i - 2 > 3) ? 3 : i - 2));
            if (i == 3) chk("t1_head", 64'(rd_data), 64'h0000_0000_A000_0000);
            adv();
        end

        // Full-rate streaming.
        do_reset();
        rd_en    = 1'b1;
        consumed = 0;
        for (int k = 0; k < 16; k++) push_src(32'hB000_0000 + 32'(k));
        for (int i = 0; i < 22; i++) begin
            sample();
            if (i < 16) chk("t2_src_rd_en", 64'(src_rd_en), 64'd1);
            if (i >= 3 && i < 19) begin
                chk("t2_rd_vld", 64'(rd_vld), 64'd1);
                chk("t2_rd_data", 64'(rd_data), 64'(32'hB000_0000 + 32'(i - 3)));
            end
            adv();
        end
        chk("t2_count", 64'(consumed), 64'd16);

        // Random ready and random source arrivals.
        do_reset();
        consumed = 0;
        pushed   = 0;
        for (int i = 0; i < 3000 && consumed < 200; i++) begin
            rd_en = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 3) != 0) begin
                push_src($urandom());
                pushed++;
            end
            sample();
            chk("t3_level_max", 64'(level <= 3), 64'd1);
            adv();
        end
        chk("t3_count", 64'(consumed), 64'd200);

        // Source runs dry, then a single late word.
        do_reset();
        rd_en    = 1'b1;
        consumed = 0;
        push_src(32'hC000_0000);
        push_src(32'hC000_0001);
        for (int i = 0; i < 14; i++) begin
            if (i == 8) push_src(32'hC000_0002);
            sample();
            chk("t4_rd_vld", 64'(rd_vld), 64'(i == 3 || i == 4 || i == 11));
            if (i == 8) chk("t4_src_rd_en", 64'(src_rd_en), 64'd1);
            adv();
        end
        chk("t4_count", 64'(consumed), 64'd3);

        // Reset with two buffered words and one in flight.
        do_reset();
        consumed = 0;
        for (int k = 0; k < 3; k++) push_src(32'hD000_0000 + 32'(k));
        for (int i = 0; i < 4; i++) begin
            sample();
            adv();
        end
        chk("t5_pre_level", 64'(level), 64'd2);
        rd_rst = 1'b1;
        model_reset();
        push_src(32'hD000_0003);
        #1;
        chk("t5_rst_rd_vld", 64'(rd_vld), 64'd0);
        chk("t5_rst_level", 64'(level), 64'd0);
        chk("t5_rst_src_rd_en", 64'(src_rd_en), 64'd0);
        sample();
        adv();
        rd_rst = 1'b0;
        rd_en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) push_src(32'hE000_0000);
            sample();
            adv();
        end
        chk("t5_count", 64'(consumed), 64'd1);

`ifdef PREFETCH_FLUSH_EN
        // Flush with two buffered words and one in flight.
        do_reset();
        consumed = 0;
        for (int k = 0; k < 3; k++) push_src(32'hF000_0000 + 32'(k));
        for (int i = 0; i < 4; i++) begin
            sample();
            adv();
        end
        chk("t6_pre_level", 64'(level), 64'd2);
        flush = 1'b1;
        push_src(32'hF000_0003);
        sample();
        chk("t6_flush_src_rd_en", 64'(src_rd_en), 64'd0);
        adv();
        flush = 1'b0;
        chk("t6_post_rd_vld", 64'(rd_vld), 64'd0);
        chk("t6_post_level", 64'(level), 64'd0);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            adv();
        end
        chk("t6_count", 64'(consumed), 64'd1);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/ipml_prefetch_rd_ctrl_v2_0.md
Name: ipml_prefetch_rd_ctrl_v2_0

Overview:
Generic first-word-fall-through (prefetch) read-side controller for the ipml FIFO family.
- Sits between a standard-mode FIFO/SDPRAM read port (pop request, data returned a fixed number of clocks later) and a valid/ready consumer.
- Generalises the fixed latency-1 / depth-2 prefetch stage to a parametrised RAM read latency and skid-buffer depth.
- Adds an occupancy output and an optional flush.

Parameters:
- DATA_WIDTH, 32, width of src_data and rd_data (1..1152).
- RD_LATENCY, 1, clocks from src_rd_en to valid src_data (1..4).
- BUF_DEPTH, 2, skid-buffer entries; must be >= RD_LATENCY+1. A violation is an elaboration error.

Ports:
- rd_clk  in  1  read clock.
- rd_rst  in  1  reset, asynchronous, active-high.
- src_empty  in  1  underlying FIFO empty flag.
- src_rd_en  out  1  pop request to underlying FIFO; each high cycle is one pop.
- src_data  in  DATA_WIDTH  underlying FIFO read data, valid RD_LATENCY clocks after src_rd_en.
- rd_data  out  DATA_WIDTH  head word to consumer.
- rd_vld  out  1  rd_data valid.
- rd_en  in  1  consumer ready; pop = rd_vld & rd_en.
- level  out  $clog2(BUF_DEPTH+1)  words held in skid buffer; excludes in-flight reads.
- flush  in  1  present only with PREFETCH_FLUSH_EN.

Behaviour:
- Reset is rd_rst, asynchronous, active-high; clock is rd_clk.
- Reset values:
  - rd_vld=0, level=0, rd_data=0.
  - src_rd_en=0: its combinational term is gated by rd_rst.
  - All in-flight flags cleared; head/tail pointers 0.
- In-flight tracking: a RD_LATENCY-deep valid shift register. Bit 0 loads src_rd_en each clock; src_data is written at buf[tail] when the last bit is 1.
- Skid buffer: circular, BUF_DEPTH entries, with head/tail pointers that wrap at BUF_DEPTH (not a power of 2 in general). Storage is not reset.
- src_rd_en = ~src_empty & ~rd_rst & ((level + inflight_cnt < BUF_DEPTH) | pop).
  - Guarantees the buffer never overflows.
  - An overflow write is a simulation assertion failure.
- rd_vld = (level != 0). rd_data = buf[head] when rd_vld, else 0.
  - rd_data is registered storage behind a mux, with no extra output register.
- Latency: src_rd_en high in cycle t → src_data sampled at end of cycle t+RD_LATENCY → rd_vld high in cycle t+RD_LATENCY+1.
- Throughput: with src never empty and rd_en held 1, one word per clock after the initial fill. This needs BUF_DEPTH >= RD_LATENCY+1.
- Handshake:
  - rd_en while ~rd_vld is ignored.
  - rd_data and rd_vld are held stable while rd_vld & ~rd_en.
  - Word order is strictly preserved.
- Simultaneous write and pop: level unchanged, both pointers advance.
- Buffer full: src_rd_en stays low unless pop occurs in the same cycle.
- src_empty: no pop request. Buffered and in-flight words still drain normally.
- Reset mid-operation: buffered and in-flight words are discarded. The underlying FIFO is reset by the same rd_rst at system level.

Optional Feature:
- Macro PREFETCH_FLUSH_EN.
- Defined: flush port exists. In a cycle with flush=1:
  - src_rd_en is forced 0 and pop is ignored.
  - At the clock edge, level←0, head←tail, and all in-flight bits are cleared, so words returning later are dropped.
  - rd_vld=0 from the next cycle.
  - Words already popped from the source are lost by design.
- Undefined: no flush port and no flush logic; behaviour is otherwise identical.

Test Plan:
1. RD_LATENCY=2, BUF_DEPTH=3, source holds A0..A9, rd_en=0 → src_rd_en high cycles 0-2 then 0; rd_vld=1 from cycle 3 with rd_data=A0; level settles at 3.
2. Same config, rd_en=1 constant, 16 words → rd_vld continuous from cycle 3; one word per clock in order A0..A15; src_rd_en high every cycle while src nonempty.
3. Random 50% rd_en with 200 words → no loss or duplication; level never >3; rd_data stable on every stalled cycle.
4. src_empty rises after 2 pops → rd_vld falls once both words are consumed. One new word is then written → rd_vld rises RD_LATENCY+1 clocks after src_rd_en.
5. rd_rst asserted with level=2 and 1 word in flight → rd_vld=0, level=0, src_rd_en=0 immediately. After release, the in-flight word never appears.
6. PREFETCH_FLUSH_EN defined, flush pulse with level=2 and 1 in flight → next cycle rd_vld=0, level=0; returning word not captured; next new word appears normally.
